// File: rtl/rr_csr_file_if.sv
// rr_csr_file_if: AXI-Lite configuration port bundle for the record/replay CSR file.
// The master modport is the host side; the slave modport is the CSR file side.
interface rr_csr_file_if #(
    parameter int AXI_ADDR_W = 32
);
    logic                  cfg_awvalid;
    logic                  cfg_awready;
    logic [AXI_ADDR_W-1:0] cfg_awaddr;
    logic                  cfg_wvalid;
    logic                  cfg_wready;
    logic [31:0]           cfg_wdata;
    logic [3:0]            cfg_wstrb;
    logic                  cfg_bvalid;
    logic                  cfg_bready;
    logic [1:0]            cfg_bresp;
    logic                  cfg_arvalid;
    logic                  cfg_arready;
    logic [AXI_ADDR_W-1:0] cfg_araddr;
    logic                  cfg_rvalid;
    logic                  cfg_rready;
    logic [31:0]           cfg_rdata;
    logic [1:0]            cfg_rresp;

    modport master (
        output cfg_awvalid, cfg_awaddr, cfg_wvalid, cfg_wdata, cfg_wstrb, cfg_bready,
               cfg_arvalid, cfg_araddr, cfg_rready,
        input  cfg_awready, cfg_wready, cfg_bvalid, cfg_bresp, cfg_arready,
               cfg_rvalid, cfg_rdata, cfg_rresp
    );

    modport slave (
        input  cfg_awvalid, cfg_awaddr, cfg_wvalid, cfg_wdata, cfg_wstrb, cfg_bready,
               cfg_arvalid, cfg_araddr, cfg_rready,
        output cfg_awready, cfg_wready, cfg_bvalid, cfg_bresp, cfg_arready,
               cfg_rvalid, cfg_rdata, cfg_rresp
    );
endinterface

// File: rtl/rr_csr_file.sv
// rr_csr_file: parametrised AXI-Lite CSR file for the record/replay control path.
// Registers are RW (with reset value), RO (sampled from ro_in) or write-to-pulse commands.
// Optional feature macro: RR_CSR_SNAPSHOT_EN -- an RO pair (2k,2k+1) gets a shadow so that
// reading LO then HI returns a consistent 64-bit value.
module rr_csr_file #(
    parameter int                    CSR_CNT    = 64,
    parameter int                    IDX_W      = $clog2(CSR_CNT),
    parameter int                    AXI_ADDR_W = 32,
    parameter logic [CSR_CNT-1:0]    RO_MASK    = '0,
    parameter logic [CSR_CNT-1:0]    PULSE_MASK = '0,
    parameter logic [CSR_CNT*32-1:0] RESET_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    rr_csr_file_if.slave          cfg,
    input  logic [CSR_CNT*32-1:0] ro_in,
    output logic [CSR_CNT*32-1:0] csr_q,
    output logic [CSR_CNT-1:0]    csr_wr_pulse
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // An address is out of range if any bit above the index field is set or the index exceeds the map.
    function automatic logic addr_oor(input logic [AXI_ADDR_W-1:0] addr);
        logic [IDX_W:0] idx_ext;
        idx_ext = {1'b0, addr[2 +: IDX_W]};
        return ((addr >> (2 + IDX_W)) != '0) || (idx_ext >= CSR_CNT[IDX_W:0]);
    endfunction

    logic                  aw_held_q, aw_held_d;
    logic [AXI_ADDR_W-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [CSR_CNT-1:0]    wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           reg_q [CSR_CNT];
    logic [31:0]           reg_d [CSR_CNT];
`ifdef RR_CSR_SNAPSHOT_EN
    logic [31:0]           shadow_q [CSR_CNT/2];
    logic [31:0]           shadow_d [CSR_CNT/2];
`endif

    logic                  aw_hs, w_hs, ar_hs, wr_fire, wr_oor, rd_oor;
    logic [AXI_ADDR_W-1:0] wr_addr;
    logic [31:0]           wr_data, strb_ext, rd_data;
    logic [3:0]            wr_strb;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign cfg.cfg_awready = ~aw_held_q & ~bvalid_q;
    assign cfg.cfg_wready  = ~w_held_q & ~bvalid_q;
    assign cfg.cfg_arready = ~rvalid_q;
    assign cfg.cfg_bvalid  = bvalid_q;
    assign cfg.cfg_bresp   = bresp_q;
    assign cfg.cfg_rvalid  = rvalid_q;
    assign cfg.cfg_rdata   = rdata_q;
    assign cfg.cfg_rresp   = rresp_q;
    assign csr_wr_pulse    = wr_pulse_q;

    assign aw_hs   = cfg.cfg_awvalid & ~aw_held_q & ~bvalid_q;
    assign w_hs    = cfg.cfg_wvalid & ~w_held_q & ~bvalid_q;
    assign ar_hs   = cfg.cfg_arvalid & ~rvalid_q;
    assign wr_fire = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    // A held beat takes precedence; otherwise the beat arriving this cycle is used directly.
    assign wr_addr  = aw_held_q ? awaddr_q : cfg.cfg_awaddr;
    assign wr_data  = w_held_q ? wdata_q : cfg.cfg_wdata;
    assign wr_strb  = w_held_q ? wstrb_q : cfg.cfg_wstrb;
    assign strb_ext = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_idx   = wr_addr[2 +: IDX_W];
    assign wr_oor   = addr_oor(wr_addr);
    assign rd_idx   = cfg.cfg_araddr[2 +: IDX_W];
    assign rd_oor   = addr_oor(cfg.cfg_araddr);

    // Write channel: hold AW/W until both are present, then issue a single response.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = cfg.cfg_awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = cfg.cfg_wdata;
            wstrb_d  = cfg.cfg_wstrb;
        end
        if (bvalid_q && cfg.cfg_bready) begin
            bvalid_d = 1'b0;
        end
        if (wr_fire) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Register next values: RO follows ro_in, pulse regs self-clear, RW regs merge strobed bytes.
    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < CSR_CNT; i++) begin
            if (RO_MASK[i]) begin
                reg_d[i] = ro_in[32*i +: 32];
            end else if (PULSE_MASK[i]) begin
                reg_d[i] = '0;
            end else begin
                reg_d[i] = reg_q[i];
            end
            if (wr_fire && !wr_oor && (wr_idx == IDX_W'(i)) && !RO_MASK[i]) begin
                wr_pulse_d[i] = 1'b1;
                if (PULSE_MASK[i]) begin
                    reg_d[i] = wr_data & strb_ext;
                end else begin
                    reg_d[i] = (wr_data & strb_ext) | (reg_q[i] & ~strb_ext);
                end
            end
        end
    end

    // Read channel: mux the addressed register (pre-commit value) into a held response.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CSR_CNT; i++) begin
            if ((rd_idx == IDX_W'(i)) && (RO_MASK[i] || !PULSE_MASK[i])) begin
                rd_data = reg_q[i];
            end
        end
`ifdef RR_CSR_SNAPSHOT_EN
        shadow_d = shadow_q;
        for (int k = 0; k < CSR_CNT/2; k++) begin
            if (RO_MASK[2*k] && RO_MASK[2*k+1]) begin
                if (rd_idx == IDX_W'(2*k+1)) begin
                    rd_data = shadow_q[k];
                end
                if (ar_hs && !rd_oor && (rd_idx == IDX_W'(2*k))) begin
                    shadow_d[k] = reg_q[2*k+1];
                end
            end
        end
`endif
        if (rd_oor) begin
            rd_data = '0;
        end
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && cfg.cfg_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_oor ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Flatten register storage onto the exported vector.
    always_comb begin
        csr_q = '0;
        for (int i = 0; i < CSR_CNT; i++) begin
            csr_q[32*i +: 32] = reg_q[i];
        end
    end

    // State registers; reset drops any in-flight transaction and restores reset values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q  <= 1'b0;
            awaddr_q   <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < CSR_CNT; i++) begin
                reg_q[i] <= (RO_MASK[i] || PULSE_MASK[i]) ? 32'h0 : RESET_VAL[32*i +: 32];
            end
`ifdef RR_CSR_SNAPSHOT_EN
            for (int k = 0; k < CSR_CNT/2; k++) begin
                shadow_q[k] <= '0;
            end
`endif
        end else begin
            aw_held_q  <= aw_held_d;
            awaddr_q   <= awaddr_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < CSR_CNT; i++) begin
                reg_q[i] <= reg_d[i];
            end
`ifdef RR_CSR_SNAPSHOT_EN
            for (int k = 0; k < CSR_CNT/2; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
`endif
        end
    end

endmodule
